// File: rtl/reg_bus_arbiter.sv
// Two-requester round-robin arbiter onto a single register-bank port.
// Each transaction runs IDLE -> ACCESS -> RESP, and every output is registered.
module reg_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    m0_req,
  input  logic                    m0_we,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_be,
  output logic                    m0_ack,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  input  logic                    m1_req,
  input  logic                    m1_we,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_be,
  output logic                    m1_ack,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic [ADDR_WIDTH-1:0]   reg_addr,
  output logic [DATA_WIDTH-1:0]   reg_wdata,
  output logic [DATA_WIDTH/8-1:0] reg_be,
  output logic                    reg_we,
  output logic                    reg_re,
  input  logic [DATA_WIDTH-1:0]   reg_rdata,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                  state;
  logic                    grant;
  logic                    last;
  logic                    cmd_we;
  logic                    win;
  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic [DATA_WIDTH/8-1:0] sel_be;

  // On a tie the requester not served last wins; otherwise the single requester wins.
  always_comb begin
    win = 1'b0;
    if (m0_req && m1_req) win = ~last;
    else                  win = m1_req;
    sel_we    = win ? m1_we    : m0_we;
    sel_addr  = win ? m1_addr  : m0_addr;
    sel_wdata = win ? m1_wdata : m0_wdata;
    sel_be    = win ? m1_be    : m0_be;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= IDLE;
      last      <= 1'b1;
      grant     <= 1'b0;
      cmd_we    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_be    <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
          if (m0_req || m1_req) begin
            grant     <= win;
            cmd_we    <= sel_we;
            reg_addr  <= sel_addr;
            reg_wdata <= sel_wdata;
            reg_be    <= sel_be;
            reg_we    <= sel_we;
            reg_re    <= ~sel_we;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          reg_we <= 1'b0;
          reg_re <= 1'b0;
          last   <= grant;
          if (!cmd_we) begin
            if (grant) m1_rdata <= reg_rdata;
            else       m0_rdata <= reg_rdata;
          end
          m0_ack <= ~grant;
          m1_ack <= grant;
          state  <= RESP;
        end
        RESP: begin
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/reg_bus_arbiter.md
REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, native bus address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, native bus data width (multiple of 8).
REQ-003 SHALL have aclk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have areset  input  1  synchronous, active-high reset.
REQ-005 SHALL have, for each requester n in {0,1}: mN_req in 1 (request), mN_we in 1 (1=write, 0=read), mN_addr in ADDR_WIDTH, mN_wdata in DATA_WIDTH, mN_be in DATA_WIDTH/8.
REQ-006 SHALL have, for each requester n: mN_ack out 1 (one-cycle completion pulse), mN_rdata out DATA_WIDTH (read data, valid while mN_ack=1).
REQ-007 SHALL have shared-port outputs: reg_addr out ADDR_WIDTH, reg_wdata out DATA_WIDTH, reg_be out DATA_WIDTH/8, reg_we out 1, reg_re out 1.
REQ-008 SHALL have reg_rdata in DATA_WIDTH, combinational read data from the register bank, valid in the same cycle as reg_re.
REQ-009 SHALL have busy out 1, high in every non-IDLE state.

Function
REQ-010 SHALL implement FSM states IDLE, ACCESS, RESP; no other reachable states.
REQ-011 IDLE: if neither req is high, SHALL remain in IDLE; otherwise it SHALL select a winner, latch the winner's we/addr/wdata/be into command registers, record grant index, and go to ACCESS.
REQ-012 Arbitration SHALL be round-robin: a single req wins; if both are high, the requester not served last wins; after reset, requester 0 wins the first tie.
REQ-013 The last-served pointer SHALL update only on entry to RESP.
REQ-014 ACCESS (exactly one cycle): reg_addr/reg_wdata/reg_be SHALL be driven from the command registers; reg_we=1 if latched we=1, else reg_re=1; never both.
REQ-015 In ACCESS, for a read, reg_rdata SHALL be captured into the granted requester's mN_rdata register; for a write, mN_rdata SHALL keep its previous value.
REQ-016 ACCESS SHALL always go to RESP.
REQ-017 RESP (exactly one cycle): the granted requester's mN_ack SHALL be 1, the other ack 0, reg_we=reg_re=0; next state IDLE.
REQ-018 Latency: req sampled high in IDLE at edge N -> reg_we/reg_re high in cycle N+1 -> ack high in cycle N+2; back-to-back throughput one transaction per 3 cycles.
REQ-019 Requesters SHALL hold req and all command fields stable until ack; changes to command fields after the IDLE latch edge SHALL NOT affect the in-flight access.
REQ-020 A requester still asserting req in the cycle after its ack SHALL be treated as a new transaction.
REQ-021 req deasserted while granted (ACCESS/RESP) SHALL NOT abort the transaction; the ack pulse still occurs.
REQ-022 reg_we, reg_re, mN_ack SHALL be 0 in every cycle outside the states stated above.
REQ-023 reg_addr/reg_wdata/reg_be SHALL hold the last latched command between transactions.
REQ-024 mN_rdata SHALL hold its value until the next read completion for that requester.

Reset
REQ-025 While areset=1 at a rising edge: state<=IDLE, last-served pointer<=1 (requester 0 favoured), command registers<=0, m0_rdata/m1_rdata<=0.
REQ-026 After reset: reg_we=reg_re=0, m0_ack=m1_ack=0, busy=0, reg_addr/reg_wdata/reg_be=0.
REQ-027 areset asserted in ACCESS or RESP SHALL abandon the transaction with no ack and no further reg_we/reg_re pulses.

Verification
REQ-028 m0 read, addr 0x10, bank returns 0xDEADBEEF -> reg_re=1 with reg_addr=0x10 in cycle N+1; m0_ack=1, m0_rdata=0xDEADBEEF in N+2; m1_ack stays 0.
REQ-029 m1 write addr 0x04, wdata 0x12345678, be 0x3 -> one reg_we pulse with those values in N+1; m1_ack in N+2; m1_rdata unchanged.
REQ-030 m0 and m1 both request continuously from reset -> grants alternate 0,1,0,1; acks every 3 cycles; no overlap of m0_ack and m1_ack.
REQ-031 m0 requests alone three times back-to-back -> served each time, ack at cycles N+2, N+5, N+8.
REQ-032 areset pulsed in ACCESS cycle of an m1 write -> no m1_ack, busy=0 next cycle, next tie goes to m0.
REQ-033 m0 changes addr 0x10->0x20 during ACCESS -> reg_addr remains 0x10 for that transaction.
